// File: rtl/cvae_state_writer.sv
// cvae_state_writer: buffers CVAE state words through a small FIFO and writes them contiguously into the state SRAM.
module cvae_state_writer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STATE_DIM  = 13,
   parameter int MAX_STEPS  = 59,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  sram_state_wea,
   output logic [ADDR_WIDTH-1:0] sram_state_addr,
   output logic [DATA_WIDTH-1:0] sram_state_wdata,
   output logic [5:0]            seq_lens,
   output logic                  busy,
   output logic                  finish,
   output logic                  overflow
);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int IW = $clog2(STATE_DIM);
   localparam int VW = $clog2(MAX_STEPS + 1);
   logic [1:0]            state;
   logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
   logic [AW:0]           wr_ptr, rd_ptr;
   logic [IW-1:0]         acc_idx, word_idx;
   logic [VW-1:0]         acc_vec, vec_cnt;
   logic [ADDR_WIDTH-1:0] base;
   logic                  ovf_seen;
   logic                  empty, full, push, pop, acc_end, acc_term, wr_end;
   logic [DATA_WIDTH:0]   head;
   always_comb begin
      empty    = wr_ptr == rd_ptr;
      full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      in_ready = (state == RUN) && !full;
      push     = in_valid && in_ready && !start;
      pop      = ((state == RUN) || (state == DRAIN)) && !empty && !start;
      head     = mem[rd_ptr[AW-1:0]];
      acc_end  = acc_idx == IW'(STATE_DIM - 1);
      wr_end   = word_idx == IW'(STATE_DIM - 1);
      // input side decides termination so in_ready drops right after the final word
      acc_term = push && acc_end && (in_last || (acc_vec == VW'(MAX_STEPS)));
      busy     = (state == RUN) || (state == DRAIN);
      finish   = state == DONE;
      overflow = (state == DONE) && ovf_seen;
   end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         acc_idx          <= '0;
         acc_vec          <= '0;
         word_idx         <= '0;
         vec_cnt          <= '0;
         base             <= '0;
         ovf_seen         <= 1'b0;
         seq_lens         <= '0;
         sram_state_wea   <= 1'b0;
         sram_state_addr  <= '0;
         sram_state_wdata <= '0;
      end else begin
         sram_state_wea <= pop;
         if (start) begin
            state    <= RUN;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            acc_idx  <= '0;
            acc_vec  <= '0;
            word_idx <= '0;
            vec_cnt  <= '0;
            base     <= '0;
            ovf_seen <= 1'b0;
            seq_lens <= '0;
         end else begin
            if (push) begin
               wr_ptr  <= wr_ptr + 1'b1;
               acc_idx <= acc_end ? '0 : acc_idx + 1'b1;
               if (acc_end) acc_vec <= acc_vec + 1'b1;
            end
            if (pop) begin
               rd_ptr           <= rd_ptr + 1'b1;
               sram_state_addr  <= base + ADDR_WIDTH'(word_idx);
               sram_state_wdata <= head[DATA_WIDTH-1:0];
               word_idx         <= wr_end ? '0 : word_idx + 1'b1;
               if (wr_end) begin
                  base    <= base + ADDR_WIDTH'(STATE_DIM);
                  vec_cnt <= vec_cnt + 1'b1;
                  if (vec_cnt != '0) seq_lens <= seq_lens + 6'd1;
                  if (vec_cnt == VW'(MAX_STEPS)) ovf_seen <= !head[DATA_WIDTH];
               end
            end
            if ((state == RUN) && acc_term) state <= DRAIN;
            if ((state == DRAIN) && empty) state <= DONE;
         end
      end
   end
endmodule

// File: doc/cvae_state_writer.md
Name: cvae_state_writer

Overview:
- Downstream stage between the CVAE compute core and the 780x32b write-only state SRAM.
- Accepts state vectors word by word over a valid/ready stream: STATE_DIM words per vector, the initial state first, then one vector per generated trajectory step.
- Writes each vector contiguously into SRAM, buffering through a small FIFO.
- Maintains seq_lens and raises a level finish flag when the sequence terminates or the SRAM trajectory region is full.

Parameters:
- DATA_WIDTH, 32, word width of stream and SRAM.
- ADDR_WIDTH, 16, SRAM address width.
- STATE_DIM, 13, words per state vector.
- MAX_STEPS, 59, maximum trajectory vectors after the initial state (60 vectors x 13 = 780 words).
- FIFO_DEPTH, 4, input buffer entries (power of two).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins or restarts a session.
- in_valid  in  1  in_data/in_last valid.
- in_ready  out  1  writer accepts this cycle.
- in_data  in  DATA_WIDTH  state word.
- in_last  in  1  marks the final word of the final vector of the sequence.
- sram_state_wea  out  1  SRAM write enable.
- sram_state_addr  out  ADDR_WIDTH  SRAM word address.
- sram_state_wdata  out  DATA_WIDTH  SRAM write data.
- seq_lens  out  6  completed trajectory vectors, excluding the initial state.
- busy  out  1  session active (RUN or DRAIN).
- finish  out  1  level; session complete, held until next start.
- overflow  out  1  level; MAX_STEPS reached without in_last, held until next start.

Behaviour:
- Reset values: in_ready=0, sram_state_wea=0, sram_state_addr=0, sram_state_wdata=0, seq_lens=0, busy=0, finish=0, overflow=0. Reset also empties the FIFO, clears all counters and forces IDLE. Reset mid-session abandons it; no further writes occur.
- Transfer rule: a word is accepted on a rising edge where in_valid && in_ready.
- in_ready = (state==RUN) && !fifo_full. When full, no push occurs even if a pop happens in the same cycle.
- FIFO pop: one word per cycle whenever the FIFO is non-empty in RUN or DRAIN.
  - A pop drives sram_state_wea=1, sram_state_addr=base+word_idx, sram_state_wdata=head, all registered outputs.
  - A word accepted at edge t can be written at edge t+2 at the earliest (wea high during the cycle after t+1 edge update). Sustained throughput is 1 word/cycle.
- Addressing:
  - word_idx counts 0..STATE_DIM-1. At wrap, base += STATE_DIM (accumulator, no multiplier) and vec_cnt increments.
  - Vector 0 is the initial state at addresses 0..12; vector k occupies 13k..13k+12.
- seq_lens increments when word_idx==STATE_DIM-1 is written for vec_cnt>=1. Its maximum value is MAX_STEPS.
- in_last is stored in the FIFO alongside the data and takes effect when popped.
  - It is honoured only on word_idx==STATE_DIM-1; on any other word it is ignored.
  - in_last on vector 0 ends the session with seq_lens=0.
- States:
  - IDLE: start -> RUN.
  - RUN: accepted word carrying a valid in_last, or the accepted word that completes vector MAX_STEPS -> DRAIN, with in_ready dropping the next cycle.
  - DRAIN: FIFO empty after the final write -> DONE.
  - DONE: finish=1; start -> RUN.
- overflow: set in DONE when termination was caused by reaching MAX_STEPS and no valid in_last was seen. If in_last arrives on the very vector that reaches MAX_STEPS, overflow=0.
- Words presented after in_ready drops are not accepted. The upstream stage holds them; the writer never drops an accepted word.
- start in RUN, DRAIN or DONE restarts the session:
  - flush the FIFO; clear base, word_idx, vec_cnt, seq_lens, finish and overflow;
  - enter RUN the next cycle with no write issued that cycle.
  - start in the same cycle as an accepted word discards that word.
- busy=1 in RUN and DRAIN.
- finish and busy are never both 1.

Test Plan:
- Reset, start, stream 13 initial words then 5 vectors (78 words total) with in_valid held high, in_last on word 78 -> addresses 0..77 written in order with data matching input, seq_lens=5, finish=1, overflow=0, zero bubbles after the first write.
- Same stream with in_valid toggled randomly and a downstream-free FIFO -> identical SRAM contents. in_ready never asserts while the FIFO holds 4 entries.
- Stream 60 vectors (780 words) with no in_last -> last write at address 779, seq_lens=59, overflow=1, finish=1. The 781st word offered is never accepted (in_ready=0).
- in_last asserted on word index 5 of vector 2, then properly on word 12 of vector 3 -> the first in_last is ignored, session ends after address 51, seq_lens=3.
- start pulse mid-vector 2 (after 30 words) -> FIFO flushed, seq_lens=0, finish=0. The next accepted word is written at address 0.
- rst_n asserted low asynchronously mid-RUN -> all outputs 0 immediately, no sram_state_wea until a new start.
